accel_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for the accelerator register slave
//  (addr/rd_en/wr_en/writedata/readdata).

---
 rtl/accel_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/accel_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the accelerator register port.
// Define ACCEL_ARB_LOCK_EN to let a requester hold the grant for up to LOCK_MAX accesses.
module accel_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_rd,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_lock,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rd,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] acc_addr,
  output logic              acc_rd_en,
  output logic              acc_wr_en,
  output logic [DATA_W-1:0] acc_writedata,
  input  logic [DATA_W-1:0] acc_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t state, state_nx;
  cmd_t   cmd0, cmd1, cmd_win;
  logic   any_req, sel, latch;
  logic   winner, rr_ptr, rr_ptr_nx;

  logic                   wr_en_nx, rd_en_nx, busy_nx;
  logic [ADDR_W-1:0]      addr_nx;
  logic [DATA_W-1:0]      wdata_nx;
  logic [1:0]             ack_nx;
  logic [1:0][DATA_W-1:0] rdata_nx;

  assign cmd0    = {r0_rd, r0_wr, r0_lock, r0_addr, r0_wdata};
  assign cmd1    = {r1_rd, r1_wr, r1_lock, r1_addr, r1_wdata};
  assign any_req = r0_req | r1_req;
  // rr_ptr only decides a contended arbitration; a lone requester always wins
  assign sel     = (r0_req & r1_req) ? rr_ptr : r1_req;
  assign cmd_win = sel ? cmd1 : cmd0;
  assign latch   = (state == IDLE) & any_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The acc_* registers double as the latched command; write wins over read
  always_comb begin
    wr_en_nx = latch & cmd_win.wr;
    rd_en_nx = latch & cmd_win.rd & ~cmd_win.wr;
    addr_nx  = latch ? cmd_win.addr  : acc_addr;
    wdata_nx = latch ? cmd_win.wdata : acc_writedata;
    ack_nx   = '0;
    rdata_nx = '0;
    if (state == ISSUE) begin
      ack_nx[winner] = 1'b1;
      if (acc_rd_en) rdata_nx[winner] = acc_readdata;
    end
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_wr_en     <= 1'b0;
      acc_rd_en     <= 1'b0;
      acc_addr      <= '0;
      acc_writedata <= '0;
      r0_ack        <= 1'b0;
      r1_ack        <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
      busy          <= 1'b0;
      winner        <= 1'b0;
      rr_ptr        <= 1'b0;
    end else begin
      acc_wr_en     <= wr_en_nx;
      acc_rd_en     <= rd_en_nx;
      acc_addr      <= addr_nx;
      acc_writedata <= wdata_nx;
      r0_ack        <= ack_nx[0];
      r1_ack        <= ack_nx[1];
      r0_rdata      <= rdata_nx[0];
      r1_rdata      <= rdata_nx[1];
      busy          <= busy_nx;
      rr_ptr        <= rr_ptr_nx;
      if (latch) winner <= sel;
    end
  end

`ifdef ACCEL_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             lock_q;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nx;

  // A locked winner keeps priority until LOCK_MAX consecutive locked grants
  always_comb begin
    rr_ptr_nx   = rr_ptr;
    lock_cnt_nx = lock_cnt;
    if (state == DONE) begin
      if (!lock_q || lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
        rr_ptr_nx   = ~winner;
        lock_cnt_nx = '0;
      end else begin
        rr_ptr_nx   = winner;
        lock_cnt_nx = lock_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      lock_cnt <= lock_cnt_nx;
      if (latch) lock_q <= cmd_win.lock;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = cmd_win.lock;

  always_comb begin
    rr_ptr_nx = rr_ptr;
    if (state == DONE) rr_ptr_nx = ~winner;
  end
`endif

endmodule
